regbus_arbiter: RTL and testbench
=================================

# regbus_arbiter

Two-requester arbiter for the 28-bit-address / 32-bit-data register bus. It shares one register bus between two masters: the Xillybus mmreq/mmresp word-pair path (requester A) and the TURF UDP control path (requester B). It sits between the PCIe/UDP front ends and the register file, all in one clock domain. The block provides round-robin grant, an optional ack timeout, and response framing for the word-stream requester.

## Interface
Parameters:
- ADDR_BITS, 28, register address width
- TIMEOUT, 64, cycles `en_o` may stay high without `ack_i` (2..65535)

Ports:
- clk  in  1  single clock for everything
- aresetn  in  1  asynchronous, active-low reset
- a_req_data  in  32  A request word stream (header, then data word)
- a_req_valid  in  1  A word present
- a_req_ready  out  1  A word accepted when valid & ready
- a_resp_data  out  32  A response word stream (status, then data)
- a_resp_valid  out  1  A response word present
- a_resp_ready  in  1  A response consumer ready
- b_en_i  in  1  B request; held high until `b_ack_o`
- b_wr_i  in  1  B write (1) / read (0)
- b_adr_i  in  ADDR_BITS  B address
- b_dat_i  in  32  B write data
- b_ack_o  out  1  one-cycle B completion pulse
- b_dat_o  out  32  B read data, valid with `b_ack_o`
- en_o  out  1  shared bus strobe
- wr_o  out  1  shared bus write
- adr_o  out  ADDR_BITS  shared bus address
- dat_o  out  32  shared bus write data
- ack_i  in  1  shared bus ack; may be combinational from `en_o`
- dat_i  in  32  shared bus read data, valid with `ack_i`
- err_count_o  out  16  saturating timeout counter

## Operation
- A header word format:
  - bit31 = write
  - bits30:28 ignored
  - bits27:0 = address
- A second word: write data. It is always sent, even for reads, and is ignored for reads.
- A staging register accepts exactly two words. After that, `a_req_ready` stays 0 until the A response is fully sent.
- A response is two words:
  - status: {wr, timeout, 2'b00, addr[27:0]}
  - data: `dat_i` for a read; the echoed write data for a write; 32'hDEADBEEF on timeout.
- B on timeout: `b_ack_o` pulses with `b_dat_o` = 32'hDEADBEEF.
- States:
  - IDLE: grant a requester.
  - BUS: `en_o` = 1, bus fields held stable.
  - A_RESP0: drive status word.
  - A_RESP1: drive data word.
  - B_ACK: `b_ack_o` = 1 for one cycle.
  - B_REL: one dead cycle so B is not regranted on a stale `b_en_i`.
- Transitions:
  - IDLE→BUS when A has a full pair or `b_en_i` is high.
  - BUS→A_RESP0 or B_ACK on `ack_i`, or on timeout.
  - A_RESP0→A_RESP1 and A_RESP1→IDLE on `a_resp_valid` & `a_resp_ready`.
  - B_ACK→B_REL→IDLE.
- Round-robin:
  - `last_grant` register, reset value = B, so A wins the first contention.
  - When both requesters are pending, grant the one not last granted. A lone requester is always granted.
- `err_count_o` increments once per timeout and saturates at 16'hFFFF.
- Reset values:
  - `en_o`, `wr_o`, `a_req_ready`, `a_resp_valid`, `b_ack_o`: 0.
  - `adr_o`, `dat_o`, `a_resp_data`, `b_dat_o`, `err_count_o`: 0.
  - State: IDLE.
- `aresetn` low mid-operation:
  - Immediately drops `en_o` and abandons any transaction.
  - Discards a partially received A pair and any unsent A response.
  - `a_req_ready` rises on the first clock after reset release.

## Timing
- All outputs are registered; there are no combinational paths from inputs to outputs.
- B latency with `ack_i` = `en_o`:
  - `b_en_i` high at cycle 0.
  - `en_o` high at cycle 1; `ack_i` is sampled in the same cycle.
  - `b_ack_o` at cycle 2.
  - Earliest B regrant: cycle 4.
- A latency with immediate ack and `a_resp_ready` = 1:
  - Second request word accepted at cycle 0.
  - `en_o` at cycle 1.
  - Status word valid at cycle 2; data word valid at cycle 3.
- `en_o` is high for exactly one cycle per transaction when `ack_i` is immediate. Otherwise it stays high until the cycle `ack_i` is sampled, then falls.
- Timeout: with no ack, `en_o` is high for exactly TIMEOUT cycles, then falls.
- `a_resp_valid` and its data are held unchanged while `a_resp_ready` = 0.
- `ack_i` outside BUS is ignored.

## Configuration
- ARB_TIMEOUT_EN defined:
  - Timeout counter is present.
  - Timeout bit, DEADBEEF substitution and `err_count_o` behave as described above.
- ARB_TIMEOUT_EN undefined:
  - BUS waits indefinitely for `ack_i`.
  - Status timeout bit is always 0.
  - `err_count_o` is tied to 16'h0000.
  - TIMEOUT is ignored.

## Test plan
- B read of address 0x0000002 with the bus returning 0x12345678 and immediate ack → `en_o` at cycle 1, `b_ack_o` at cycle 2 with `b_dat_o` = 0x12345678, B regrant no earlier than cycle 4.
- A pair {0x80000002, 0xCAFEF00D} → bus write to address 2 with data 0xCAFEF00D; response {0x80000002, 0xCAFEF00D}.
- A pair and `b_en_i` both pending after reset → A granted first, then B. A second simultaneous pending pair → B, then A alternate.
- Ack withheld, TIMEOUT = 64, B read:
  - With ARB_TIMEOUT_EN: `en_o` high for 64 cycles, then `b_dat_o` = 0xDEADBEEF and `err_count_o` = 1.
  - Without ARB_TIMEOUT_EN: `en_o` stays high and no ack is produced.
- `a_resp_ready` held 0 for 10 cycles during the response → status word held stable and `a_req_ready` stays 0; the response completes after `a_resp_ready` rises.
- `aresetn` asserted while `en_o` is high and while one A word is staged → all outputs return to 0 asynchronously. After release, a fresh A pair executes correctly.

Source files
------------

// File: rtl/regbus_arbiter.sv
// -----------------------------------------------------------------------------
// regbus_arbiter
//
// Shares one 28-bit-address / 32-bit-data register bus between two masters:
//   A: word-stream requester (mmreq/mmresp pairs). It sends a header word
//      {wr, 3'bx, addr[27:0]} followed by a data word. It receives a status word
//      {wr, timeout, 2'b00, addr[27:0]} followed by a data word.
//   B: strobe/ack requester (UDP control path). It holds en high until it
//      receives a one-cycle ack pulse.
// Grants alternate round-robin when both requesters are pending; a lone
// requester is always granted. Every output is registered.
//
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   -> the bus strobe is abandoned after TIMEOUT cycles without ack.
//                The requester gets 32'hDEADBEEF, and err_count_o counts these
//                events, saturating at its maximum.
//   undefined -> BUS waits for ack_i forever and err_count_o is tied to zero.
//
// Ports:
//   clk, aresetn        single clock, asynchronous active-low reset
//   a_req_*             A request word stream (valid/ready)
//   a_resp_*            A response word stream (valid/ready)
//   b_en_i/b_wr_i/b_adr_i/b_dat_i -> b_ack_o/b_dat_o   B strobe/ack port
//   en_o/wr_o/adr_o/dat_o <- ack_i/dat_i   shared register bus
//   err_count_o         saturating timeout counter
// -----------------------------------------------------------------------------
module regbus_arbiter #(
    parameter int ADDR_BITS = 28,
    parameter int TIMEOUT   = 64
) (
    input  logic                 clk,
    input  logic                 aresetn,
    input  logic [31:0]          a_req_data,
    input  logic                 a_req_valid,
    output logic                 a_req_ready,
    output logic [31:0]          a_resp_data,
    output logic                 a_resp_valid,
    input  logic                 a_resp_ready,
    input  logic                 b_en_i,
    input  logic                 b_wr_i,
    input  logic [ADDR_BITS-1:0] b_adr_i,
    input  logic [31:0]          b_dat_i,
    output logic                 b_ack_o,
    output logic [31:0]          b_dat_o,
    output logic                 en_o,
    output logic                 wr_o,
    output logic [ADDR_BITS-1:0] adr_o,
    output logic [31:0]          dat_o,
    input  logic                 ack_i,
    input  logic [31:0]          dat_i,
    output logic [15:0]          err_count_o
);

    localparam logic [31:0] DEAD_WORD = 32'hDEAD_BEEF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_BUS,
        S_A_RESP0,
        S_A_RESP1,
        S_B_ACK,
        S_B_REL
    } state_t;

    typedef enum logic {
        GNT_A,
        GNT_B
    } grant_t;

    state_t      state;
    grant_t      last_grant;
    grant_t      owner;

    // A staging register: word count (0, 1 or 2), header fields and data word.
    logic [1:0]  a_cnt;
    logic        a_hdr_wr;
    logic [27:0] a_hdr_adr;
    logic [31:0] a_wdata;
    // Second response word, prepared when the bus transaction ends.
    logic [31:0] a_resp_next;

    logic        a_accept;
    logic        a_full;
    logic [31:0] a_wdata_now;
    logic        to_hit;

    assign a_accept = a_req_valid & a_req_ready;

    // A pair is treated as complete in the same cycle its second word is
    // accepted. This lets the grant happen one cycle earlier.
    assign a_full      = (a_cnt == 2'd2) || ((a_cnt == 2'd1) && a_accept);
    assign a_wdata_now = ((a_cnt == 2'd1) && a_accept) ? a_req_data : a_wdata;

    // Header bits 30:28 carry no meaning.
    logic unused_hdr_bits;
    assign unused_hdr_bits = ^a_req_data[30:28];

`ifdef ARB_TIMEOUT_EN
    logic [15:0] to_cnt;
    logic [15:0] err_count;

    // The timeout fires in the TIMEOUT-th BUS cycle. This holds en_o high
    // for exactly TIMEOUT cycles. An ack in that same cycle takes priority.
    assign to_hit = (state == S_BUS) && !ack_i && (to_cnt == 16'(TIMEOUT - 1));

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            to_cnt    <= '0;
            err_count <= '0;
        end else begin
            if ((state != S_BUS) || ack_i || to_hit) begin
                to_cnt <= '0;
            end else begin
                to_cnt <= to_cnt + 16'd1;
            end
            if (to_hit && (err_count != 16'hFFFF)) begin
                err_count <= err_count + 16'd1;
            end
        end
    end

    assign err_count_o = err_count;
`else
    localparam int unused_timeout = TIMEOUT;

    assign to_hit      = 1'b0;
    assign err_count_o = 16'h0000;
`endif

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            state        <= S_IDLE;
            last_grant   <= GNT_B;
            owner        <= GNT_A;
            a_cnt        <= '0;
            a_hdr_wr     <= 1'b0;
            a_hdr_adr    <= '0;
            a_wdata      <= '0;
            a_resp_next  <= '0;
            a_req_ready  <= 1'b0;
            a_resp_valid <= 1'b0;
            a_resp_data  <= '0;
            b_ack_o      <= 1'b0;
            b_dat_o      <= '0;
            en_o         <= 1'b0;
            wr_o         <= 1'b0;
            adr_o        <= '0;
            dat_o        <= '0;
        end else begin
            // NOTE: state is written with <= throughout, so every branch reads
            // the values from before this edge regardless of statement order.
            b_ack_o <= 1'b0;

            // A staging. Ready is dropped as soon as the second word is
            // taken, and it returns only after the response has been sent.
            if (a_accept) begin
                a_cnt       <= a_cnt + 2'd1;
                a_req_ready <= (a_cnt == 2'd0);
                if (a_cnt == 2'd0) begin
                    a_hdr_wr  <= a_req_data[31];
                    a_hdr_adr <= a_req_data[27:0];
                end else begin
                    a_wdata <= a_req_data;
                end
            end else if (a_cnt != 2'd2) begin
                a_req_ready <= 1'b1;
            end

            unique case (state)
                S_IDLE: begin
                    if (a_full && (!b_en_i || (last_grant == GNT_B))) begin
                        owner      <= GNT_A;
                        last_grant <= GNT_A;
                        en_o       <= 1'b1;
                        wr_o       <= a_hdr_wr;
                        adr_o      <= a_hdr_adr[ADDR_BITS-1:0];
                        dat_o      <= a_wdata_now;
                        state      <= S_BUS;
                    end else if (b_en_i) begin
                        owner      <= GNT_B;
                        last_grant <= GNT_B;
                        en_o       <= 1'b1;
                        wr_o       <= b_wr_i;
                        adr_o      <= b_adr_i;
                        dat_o      <= b_dat_i;
                        state      <= S_BUS;
                    end
                end

                S_BUS: begin
                    if (ack_i || to_hit) begin
                        en_o <= 1'b0;
                        if (owner == GNT_A) begin
                            a_resp_valid <= 1'b1;
                            a_resp_data  <= {a_hdr_wr, to_hit, 2'b00, a_hdr_adr};
                            if (to_hit) begin
                                a_resp_next <= DEAD_WORD;
                            end else if (a_hdr_wr) begin
                                a_resp_next <= a_wdata;
                            end else begin
                                a_resp_next <= dat_i;
                            end
                            state <= S_A_RESP0;
                        end else begin
                            b_ack_o <= 1'b1;
                            b_dat_o <= to_hit ? DEAD_WORD : dat_i;
                            state   <= S_B_ACK;
                        end
                    end
                end

                S_A_RESP0: begin
                    if (a_resp_ready) begin
                        a_resp_data <= a_resp_next;
                        state       <= S_A_RESP1;
                    end
                end

                S_A_RESP1: begin
                    if (a_resp_ready) begin
                        a_resp_valid <= 1'b0;
                        a_cnt        <= '0;
                        a_req_ready  <= 1'b1;
                        state        <= S_IDLE;
                    end
                end

                S_B_ACK: begin
                    state <= S_B_REL;
                end

                // B still shows its old b_en_i here. Skip one cycle so that
                // request is not taken as a new one.
                S_B_REL: begin
                    state <= S_IDLE;
                end

                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_regbus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_regbus_arbiter
//
// Directed bench for regbus_arbiter. It covers reset values, B and A
// transaction latency, back-pressure on the A response, round-robin
// alternation, the ack-withheld case (either build, selected by
// ARB_TIMEOUT_EN), and an asynchronous reset in mid-transaction.
// The shared bus acks combinationally (ack_i = en_o & ack_en).
// Inputs are driven and outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_regbus_arbiter;

    logic        clk;
    logic        aresetn;
    logic [31:0] a_req_data;
    logic        a_req_valid;
    logic        a_req_ready;
    logic [31:0] a_resp_data;
    logic        a_resp_valid;
    logic        a_resp_ready;
    logic        b_en_i;
    logic        b_wr_i;
    logic [27:0] b_adr_i;
    logic [31:0] b_dat_i;
    logic        b_ack_o;
    logic [31:0] b_dat_o;
    logic        en_o;
    logic        wr_o;
    logic [27:0] adr_o;
    logic [31:0] dat_o;
    logic        ack_i;
    logic [31:0] dat_i;
    logic [15:0] err_count_o;

    logic        ack_en;
    int          n_tests;
    int          n_fail;
    int          hi_cnt;
    logic        ack_seen;
    logic [31:0] ack_dat;

    regbus_arbiter #(
        .ADDR_BITS (28),
        .TIMEOUT   (64)
    ) dut (
        .clk          (clk),
        .aresetn      (aresetn),
        .a_req_data   (a_req_data),
        .a_req_valid  (a_req_valid),
        .a_req_ready  (a_req_ready),
        .a_resp_data  (a_resp_data),
        .a_resp_valid (a_resp_valid),
        .a_resp_ready (a_resp_ready),
        .b_en_i       (b_en_i),
        .b_wr_i       (b_wr_i),
        .b_adr_i      (b_adr_i),
        .b_dat_i      (b_dat_i),
        .b_ack_o      (b_ack_o),
        .b_dat_o      (b_dat_o),
        .en_o         (en_o),
        .wr_o         (wr_o),
        .adr_o        (adr_o),
        .dat_o        (dat_o),
        .ack_i        (ack_i),
        .dat_i        (dat_i),
        .err_count_o  (err_count_o)
    );

    assign ack_i = en_o & ack_en;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] observed,
                         input logic [31:0] expected);
        n_tests++;
        assert (observed === expected) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, observed, expected);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    initial begin
        n_tests      = 0;
        n_fail       = 0;
        aresetn      = 1'b0;
        a_req_data   = '0;
        a_req_valid  = 1'b0;
        a_resp_ready = 1'b1;
        b_en_i       = 1'b0;
        b_wr_i       = 1'b0;
        b_adr_i      = '0;
        b_dat_i      = '0;
        dat_i        = '0;
        ack_en       = 1'b1;

        // ---------------- reset values ----------------
        step(2);
        check("rst_en",        32'(en_o),         32'h0);
        check("rst_req_ready", 32'(a_req_ready),  32'h0);
        check("rst_resp_valid",32'(a_resp_valid), 32'h0);
        check("rst_b_ack",     32'(b_ack_o),      32'h0);
        check("rst_adr",       32'(adr_o),        32'h0);
        check("rst_err",       32'(err_count_o),  32'h0);
        aresetn = 1'b1;
        check("rel_req_ready0",32'(a_req_ready),  32'h0);
        step(1);
        check("rel_req_ready1",32'(a_req_ready),  32'h1);

        // ---------------- B read, immediate ack ----------------
        // cycle 0
        b_en_i  = 1'b1;
        b_wr_i  = 1'b0;
        b_adr_i = 28'h000_0002;
        dat_i   = 32'h1234_5678;
        step(1); // cycle 1
        check("b_en_c1",       32'(en_o),    32'h1);
        check("b_adr_c1",      32'(adr_o),   32'h2);
        check("b_wr_c1",       32'(wr_o),    32'h0);
        check("b_ack_c1",      32'(b_ack_o), 32'h0);
        step(1); // cycle 2
        check("b_ack_c2",      32'(b_ack_o), 32'h1);
        check("b_dat_c2",      b_dat_o,      32'h1234_5678);
        check("b_en_c2",       32'(en_o),    32'h0);
        step(1); // cycle 3, b_en_i deliberately left high
        check("b_ack_c3",      32'(b_ack_o), 32'h0);
        check("b_en_c3",       32'(en_o),    32'h0);
        step(2); // cycle 5
        check("b_regrant_c5",  32'(en_o),    32'h1);
        step(1); // cycle 6
        check("b_ack2_c6",     32'(b_ack_o), 32'h1);
        b_en_i = 1'b0;
        step(2);

        // ---------------- A write pair ----------------
        a_req_valid = 1'b1;
        a_req_data  = 32'h8000_0002;
        step(1); // cycle 0: second word
        a_req_data  = 32'hCAFE_F00D;
        step(1); // cycle 1
        a_req_valid = 1'b0;
        check("aw_en_c1",      32'(en_o),        32'h1);
        check("aw_wr_c1",      32'(wr_o),        32'h1);
        check("aw_adr_c1",     32'(adr_o),       32'h2);
        check("aw_dat_c1",     dat_o,            32'hCAFE_F00D);
        check("aw_ready_c1",   32'(a_req_ready), 32'h0);
        step(1); // cycle 2
        check("aw_stat_valid", 32'(a_resp_valid),32'h1);
        check("aw_stat",       a_resp_data,      32'h8000_0002);
        check("aw_en_c2",      32'(en_o),        32'h0);
        step(1); // cycle 3
        check("aw_data_valid", 32'(a_resp_valid),32'h1);
        check("aw_data",       a_resp_data,      32'hCAFE_F00D);
        step(1); // cycle 4
        check("aw_done_valid", 32'(a_resp_valid),32'h0);
        check("aw_done_ready", 32'(a_req_ready), 32'h1);

        // ---------------- A read with response back-pressure ----------------
        a_req_valid  = 1'b1;
        a_req_data   = 32'h0000_0010;
        step(1);
        a_req_data   = 32'h1111_1111;
        dat_i        = 32'hA5A5_0001;
        a_resp_ready = 1'b0;
        step(1); // cycle 1
        a_req_valid  = 1'b0;
        check("ar_en_c1",      32'(en_o),  32'h1);
        check("ar_wr_c1",      32'(wr_o),  32'h0);
        check("ar_adr_c1",     32'(adr_o), 32'h10);
        step(1); // cycle 2
        check("ar_stat",       a_resp_data, 32'h0000_0010);
        for (int i = 0; i < 9; i++) begin
            step(1);
            check("ar_hold_stat",  a_resp_data,        32'h0000_0010);
            check("ar_hold_valid", 32'(a_resp_valid),  32'h1);
            check("ar_hold_ready", 32'(a_req_ready),   32'h0);
        end
        a_resp_ready = 1'b1;
        step(1);
        check("ar_data",       a_resp_data,       32'hA5A5_0001);
        check("ar_data_valid", 32'(a_resp_valid), 32'h1);
        step(1);
        check("ar_done_valid", 32'(a_resp_valid), 32'h0);

        // ---------------- round-robin after fresh reset ----------------
        aresetn = 1'b0;
        step(1);
        aresetn = 1'b1;
        step(1);
        a_req_valid = 1'b1;
        a_req_data  = 32'h8000_0005;
        step(1); // cycle 0: A second word and B request together
        a_req_data  = 32'h0000_0055;
        b_en_i      = 1'b1;
        b_wr_i      = 1'b1;
        b_adr_i     = 28'h000_0009;
        b_dat_i     = 32'h0000_0099;
        step(1); // cycle 1
        a_req_valid = 1'b0;
        check("rr_first_en",   32'(en_o),  32'h1);
        check("rr_first_is_a", 32'(adr_o), 32'h5);
        step(3); // cycle 4
        check("rr_c4_en",      32'(en_o),        32'h0);
        check("rr_c4_ready",   32'(a_req_ready), 32'h1);
        a_req_valid = 1'b1;
        a_req_data  = 32'h8000_0006;
        step(1); // cycle 5
        check("rr_second_en",  32'(en_o),  32'h1);
        check("rr_second_is_b",32'(adr_o), 32'h9);
        a_req_data  = 32'h0000_0066;
        step(1); // cycle 6
        a_req_valid = 1'b0;
        check("rr_b_ack",      32'(b_ack_o), 32'h1);
        b_adr_i = 28'h000_000A;
        b_dat_i = 32'h0000_00AA;
        step(3); // cycle 9
        check("rr_third_en",   32'(en_o),  32'h1);
        check("rr_third_is_a", 32'(adr_o), 32'h6);
        step(4); // cycle 13
        check("rr_fourth_en",  32'(en_o),  32'h1);
        check("rr_fourth_is_b",32'(adr_o), 32'hA);
        step(1); // cycle 14
        check("rr_b_ack2",     32'(b_ack_o), 32'h1);
        b_en_i = 1'b0;
        step(3);

        // ---------------- ack withheld, B read ----------------
        ack_en      = 1'b0;
        b_en_i      = 1'b1;
        b_wr_i      = 1'b0;
        b_adr_i     = 28'h000_0003;
        a_req_valid = 1'b1;
        a_req_data  = 32'h8000_0007;   // single staged A word
        step(1);
        a_req_valid = 1'b0;
        hi_cnt   = 0;
        ack_seen = 1'b0;
        ack_dat  = '0;
        for (int i = 0; i < 80; i++) begin
            if (en_o) hi_cnt++;
            if (b_ack_o) begin
                ack_seen = 1'b1;
                ack_dat  = b_dat_o;
                b_en_i   = 1'b0;
            end
            step(1);
        end
        check("to_one_word_ready", 32'(a_req_ready), 32'h1);
`ifdef ARB_TIMEOUT_EN
        check("to_en_cycles",  32'(hi_cnt),      32'd64);
        check("to_ack_seen",   32'(ack_seen),    32'h1);
        check("to_dead_word",  ack_dat,          32'hDEAD_BEEF);
        check("to_err_count",  32'(err_count_o), 32'h1);
`else
        check("to_en_cycles",  32'(hi_cnt),      32'd80);
        check("to_ack_seen",   32'(ack_seen),    32'h0);
        check("to_err_count",  32'(err_count_o), 32'h0);
`endif

        // ---------------- async reset while en_o high ----------------
        b_en_i = 1'b1;
        step(2);
        check("ar_pre_en",     32'(en_o), 32'h1);
        #2;
        aresetn = 1'b0;
        #1;
        check("ar_async_en",    32'(en_o),         32'h0);
        check("ar_async_wr",    32'(wr_o),         32'h0);
        check("ar_async_adr",   32'(adr_o),        32'h0);
        check("ar_async_dat",   dat_o,             32'h0);
        check("ar_async_ready", 32'(a_req_ready),  32'h0);
        check("ar_async_err",   32'(err_count_o),  32'h0);
        b_en_i = 1'b0;
        ack_en = 1'b1;
        step(1);
        aresetn = 1'b1;
        check("ar_rel_ready0",  32'(a_req_ready), 32'h0);
        step(1);
        check("ar_rel_ready1",  32'(a_req_ready), 32'h1);

        // ---------------- fresh A read after reset ----------------
        a_req_valid = 1'b1;
        a_req_data  = 32'h0000_0004;
        step(1);
        a_req_data  = 32'h0000_1234;
        dat_i       = 32'h0BAD_C0DE;
        step(1); // cycle 1
        a_req_valid = 1'b0;
        check("fr_en",         32'(en_o),  32'h1);
        check("fr_wr",         32'(wr_o),  32'h0);
        check("fr_adr",        32'(adr_o), 32'h4);
        step(1);
        check("fr_stat",       a_resp_data,       32'h0000_0004);
        check("fr_stat_valid", 32'(a_resp_valid), 32'h1);
        step(1);
        check("fr_data",       a_resp_data,       32'h0BAD_C0DE);
        step(1);
        check("fr_done_valid", 32'(a_resp_valid), 32'h0);
        check("fr_done_ready", 32'(a_req_ready),  32'h1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
